seg_scan_ctrl: RTL and testbench

Time-multiplexed digit scan controller for the 8-digit seven-segment display. It generates the 3-bit digit select that drives the 8x1 nibble mux upstream of the hex-to-seven-segment decoder. It also drives the active-low anode enables and the decimal point for the same digit. A blanking window at the start of each digit slot suppresses ghosting while the mux/decoder path settles.

---
 rtl/seg_scan_ctrl.sv | 86 ++++++++
 tb/tb_seg_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Digit scan controller for an 8-digit multiplexed seven-segment display.
// Each digit gets a TICK_DIV-cycle slot. The first BLANK_CYC cycles of the slot keep all anodes off.
module seg_scan_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] digit_en,
  input  logic [7:0] dp_in,
  output logic [2:0] sel,
  output logic [7:0] anode,
  output logic       dp,
  output logic       slot_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       anode_q, anode_d;
  logic             dp_q, dp_d;
  logic             slot_tick_q, slot_tick_d;
  logic             past_blank;
  logic             active;

  always_comb begin
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    slot_tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d       = '0;
        sel_d       = sel_q + 3'd1;
        slot_tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // With blanking disabled, the compare against zero is dropped so that no constant compare is elaborated.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign past_blank = 1'b1;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYC);
      assign past_blank = (cnt_d >= BLANK_V);
    end
  endgenerate

  // Anode and dp are computed from the next-state sel and cnt, so they are registered in step with sel.
  always_comb begin
    active  = enable & digit_en[sel_d] & past_blank;
    anode_d = 8'hFF;
    dp_d    = 1'b1;
    if (active) begin
      anode_d = ~(8'b1 << sel_d);
      dp_d    = ~dp_in[sel_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      sel_q       <= 3'd0;
      anode_q     <= 8'hFF;
      dp_q        <= 1'b1;
      slot_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      anode_q     <= anode_d;
      dp_q        <= dp_d;
      slot_tick_q <= slot_tick_d;
    end
  end

  assign sel       = sel_q;
  assign anode     = anode_q;
  assign dp        = dp_q;
  assign slot_tick = slot_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: runs directed scenarios and random stimulus on two instances, one with blanking and one without.
// Both instances are checked every cycle against a slot/digit reference model.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] digit_en;
  logic [7:0] dp_in;

  logic [2:0] sel0, sel1;
  logic [7:0] anode0, anode1;
  logic       dp0, dp1, tick0, tick1;

  int n_cmp = 0;
  int n_err = 0;

  int         m_cnt[2];
  int         m_sel[2];
  logic [7:0] m_anode[2];
  logic       m_dp[2];
  logic       m_tick[2];
  int         blank[2] = '{2, 0};

  always #5 clk = ~clk;

  seg_scan_ctrl #(.TICK_DIV(10), .BLANK_CYC(2)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en), .dp_in(dp_in),
    .sel(sel0), .anode(anode0), .dp(dp0), .slot_tick(tick0)
  );

  seg_scan_ctrl #(.TICK_DIV(10), .BLANK_CYC(0)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en), .dp_in(dp_in),
    .sel(sel1), .anode(anode1), .dp(dp1), .slot_tick(tick1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: one slot is 10 cycles, and 8 slots make one scan. A digit is lit past the blank window when it is enabled.
  task automatic model_update(input int i);
    if (reset) begin
      m_cnt[i] = 0; m_sel[i] = 0; m_anode[i] = 8'hFF; m_dp[i] = 1'b1; m_tick[i] = 1'b0;
    end else if (!enable) begin
      m_tick[i] = 1'b0; m_anode[i] = 8'hFF; m_dp[i] = 1'b1;
    end else begin
      m_tick[i] = (m_cnt[i] == 9);
      if (m_cnt[i] == 9) begin
        m_cnt[i] = 0;
        m_sel[i] = (m_sel[i] + 1) % 8;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
      if (digit_en[m_sel[i]] && m_cnt[i] >= blank[i]) begin
        m_anode[i] = 8'hFF - 8'(1 << m_sel[i]);
        m_dp[i]    = !dp_in[m_sel[i]];
      end else begin
        m_anode[i] = 8'hFF;
        m_dp[i]    = 1'b1;
      end
    end
  endtask

  task automatic check_one(input int i, input logic [2:0] s, input logic [7:0] a,
                           input logic d, input logic t, input int c);
    chk($sformatf("sel%0d", i), 32'(s), 32'(m_sel[i]));
    chk($sformatf("anode%0d", i), 32'(a), 32'(m_anode[i]));
    chk($sformatf("dp%0d", i), 32'(d), 32'(m_dp[i]));
    chk($sformatf("tick%0d", i), 32'(t), 32'(m_tick[i]));
    chk($sformatf("cnt%0d", i), 32'(c), 32'(m_cnt[i]));
    chk($sformatf("onehot%0d", i), 32'($countones(~a) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    check_one(0, sel0, anode0, dp0, tick0, int'(dut0.cnt_q));
    check_one(1, sel1, anode1, dp1, tick1, int'(dut1.cnt_q));
  endtask

  task automatic run_to(input int s, input int c);
    int n;
    n = 0;
    while (!(m_sel[0] == s && m_cnt[0] == c) && n < 200) begin
      step();
      n++;
    end
    chk("run_to", 32'(m_sel[0] == s && m_cnt[0] == c), 32'd1);
  endtask

  initial begin
    int ticks;
    int dp_low;
    int ff_cnt;
    reset = 1'b1; enable = 1'b1; digit_en = 8'hFF; dp_in = 8'h00;

    // Scenario 1: reset hold, then the first slot after release
    repeat (3) begin
      step();
      chk("rst_sel", 32'(sel0), 32'd0);
      chk("rst_anode", 32'(anode0), 32'hFF);
      chk("rst_dp", 32'(dp0), 32'd1);
      chk("rst_tick", 32'(tick0), 32'd0);
    end
    reset = 1'b0;
    for (int k = 1; k < 10; k++) begin
      step();
      chk("s1_sel", 32'(sel0), 32'd0);
      chk("s1_anode", 32'(anode0), (k >= 2) ? 32'hFE : 32'hFF);
    end

    // Scenario 2: full scan of 80 cycles, both instances
    reset = 1'b1; step(); reset = 1'b0;
    ticks = 0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (tick0) ticks++;
      if (k <= 20) chk("nb_anode", 32'(anode1), 32'(8'hFF ^ 8'(1 << (k / 10))));
    end
    chk("s2_ticks", 32'(ticks), 32'd8);
    chk("s2_wrap", 32'(sel0), 32'd0);

    // Scenario 3: digit mask and decimal point
    digit_en = 8'b1010_0101; dp_in = 8'h04;
    dp_low = 0; ff_cnt = 0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (!dp0) dp_low++;
      if (anode0 == 8'hFF) ff_cnt++;
      if (!dp0) chk("s3_dp_anode", 32'(anode0), 32'hFB);
    end
    chk("s3_dp_low", 32'(dp_low), 32'd8);
    chk("s3_ff_cnt", 32'(ff_cnt), 32'd48);

    // Scenario 4: freeze at sel=3, cnt=5
    digit_en = 8'hFF; dp_in = 8'h00;
    run_to(3, 5);
    enable = 1'b0;
    repeat (7) begin
      step();
      chk("s4_sel", 32'(sel0), 32'd3);
      chk("s4_cnt", 32'(dut0.cnt_q), 32'd5);
      chk("s4_anode", 32'(anode0), 32'hFF);
      chk("s4_tick", 32'(tick0), 32'd0);
    end
    enable = 1'b1;
    repeat (4) step();
    chk("s4_resume_sel", 32'(sel0), 32'd3);
    step();
    chk("s4_adv_sel", 32'(sel0), 32'd4);
    chk("s4_adv_tick", 32'(tick0), 32'd1);

    // Scenario 5: enable falls on the wrap cycle; reset inside the blank window
    run_to(5, 9);
    enable = 1'b0;
    step();
    chk("s5_nowrap_sel", 32'(sel0), 32'd5);
    chk("s5_nowrap_tick", 32'(tick0), 32'd0);
    enable = 1'b1;
    step();
    chk("s5_wrap_sel", 32'(sel0), 32'd6);
    run_to(6, 1);
    reset = 1'b1;
    step();
    chk("s5_rst_sel", 32'(sel0), 32'd0);
    chk("s5_rst_cnt", 32'(dut0.cnt_q), 32'd0);
    chk("s5_rst_anode", 32'(anode0), 32'hFF);
    reset = 1'b0;

    // Random phase
    for (int k = 0; k < 600; k++) begin
      enable   = ($urandom % 8) != 0;
      reset    = ($urandom % 64) == 0;
      if ($urandom % 16 == 0) digit_en = 8'($urandom);
      if ($urandom % 16 == 0) dp_in    = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
